// File: rtl/prng_pkg.sv
// ---------------------------------------------------------------------------
// prng_pkg
//   Shared definitions for the pseudo-random stream generator:
//     - state_e        : generator control state (UNSEEDED / RUN)
//     - MODE_*         : encodings of the mode_i output-range selector
//     - DEFAULT_TAPS_8 : Galois feedback mask for x^8+x^6+x^5+x^4+1
// ---------------------------------------------------------------------------
package prng_pkg;

   // Control state. The encoding is kept one bit wide so the register can be
   // read directly as the "seeded" flag.
   typedef enum logic [0:0] {
      ST_UNSEEDED = 1'b0,
      ST_RUN      = 1'b1
   } state_e;

   // Output range selector
   localparam logic [1:0] MODE_FULL    = 2'd0;  // full OUT_WIDTH range
   localparam logic [1:0] MODE_QUAD    = 2'd1;  // 0..3
   localparam logic [1:0] MODE_NONZERO = 2'd2;  // 1..2^OUT_WIDTH-1
   localparam logic [1:0] MODE_RSVD    = 2'd3;  // behaves as MODE_FULL

   // Maximal-length 8-bit Galois mask: x^8+x^6+x^5+x^4+1
   localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;

endpackage : prng_pkg

// File: rtl/lfsr_galois_step.sv
// ---------------------------------------------------------------------------
// lfsr_galois_step
//   Purely combinational single step of a right-shifting Galois LFSR:
//     next = state >> 1, XORed with TAPS when the bit shifted out is 1.
//
//   Parameters
//     WIDTH   : LFSR state width
//     TAPS    : feedback mask applied when state_i[0] = 1
//   Ports
//     state_i : current LFSR state
//     next_o  : state after one step
// ---------------------------------------------------------------------------
module lfsr_galois_step #(
   parameter int unsigned             WIDTH = 8,
   parameter logic [WIDTH-1:0]        TAPS  = 8'hB8
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] feedback;

   always_comb begin
      shifted  = state_i >> 1;
      feedback = state_i[0] ? TAPS : '0;
      next_o   = shifted ^ feedback;
   end

endmodule : lfsr_galois_step

// File: rtl/prng_stream.sv
// ---------------------------------------------------------------------------
// prng_stream
//   Seeded Galois-LFSR random number source with a valid/ready output.
//   After a seed is loaded the generator steps once per accepted word and
//   presents a range-shaped number on rand_o. The word is held stable until
//   the consumer takes it.
//
//   Parameters
//     WIDTH        : LFSR state width (4..32)
//     OUT_WIDTH    : output word width (2..WIDTH)
//     TAPS         : Galois feedback mask
//     DEFAULT_SEED : used in place of an all-zero seed (0 is a lock-up state)
//   Ports
//     clk_i        : clock
//     rst_i        : asynchronous, active-low reset
//     seed_valid_i : load seed_i this cycle (overrides any handshake)
//     seed_i       : seed value
//     mode_i       : 0/3 full range, 1 -> 0..3, 2 -> nonzero only
//     rand_ready_i : consumer accepts rand_o
//     rand_valid_o : rand_o holds a valid number
//     rand_o       : random number
//     seeded_o     : a seed has been loaded since reset
//     gen_cnt_o    : number of accepted handshakes (wraps at 16 bits)
// ---------------------------------------------------------------------------
module prng_stream
   import prng_pkg::*;
#(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      OUT_WIDTH    = 8,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(DEFAULT_TAPS_8),
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 seed_valid_i,
   input  logic [WIDTH-1:0]     seed_i,
   input  logic [1:0]           mode_i,
   input  logic                 rand_ready_i,
   output logic                 rand_valid_o,
   output logic [OUT_WIDTH-1:0] rand_o,
   output logic                 seeded_o,
   output logic [15:0]          gen_cnt_o
);

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       lfsr_q, lfsr_d;
   logic [OUT_WIDTH-1:0]   rand_q, rand_d;
   logic                   valid_q, valid_d;
   logic [15:0]            cnt_q, cnt_d;

   logic [WIDTH-1:0]       lfsr_next;
   logic [OUT_WIDTH-1:0]   cand;
   logic                   reject;
   logic                   advance;
   logic                   handshake;

   lfsr_galois_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .state_i (lfsr_q),
      .next_o  (lfsr_next)
   );

   // Shape the freshly stepped state into the requested output range.
   // Only the nonzero mode can reject a candidate.
   always_comb begin
      cand   = '0;
      reject = 1'b0;
      case (mode_i)
         MODE_QUAD: begin
            cand[1:0] = lfsr_next[1:0];
         end
         MODE_NONZERO: begin
            cand   = lfsr_next[OUT_WIDTH-1:0];
            reject = (lfsr_next[OUT_WIDTH-1:0] == '0);
         end
         MODE_FULL, MODE_RSVD: begin
            cand = lfsr_next[OUT_WIDTH-1:0];
         end
         default: begin
            cand = lfsr_next[OUT_WIDTH-1:0];
         end
      endcase
   end

   // Step only when the output slot is free or being emptied this cycle;
   // this is what keeps a held word (and the LFSR behind it) frozen.
   always_comb begin
      advance   = (state_q == ST_RUN) && (!valid_q || rand_ready_i);
      handshake = valid_q && rand_ready_i;
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      rand_d  = rand_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;

      if (seed_valid_i) begin
         // Seed load wins: a pending word is dropped and not counted.
         lfsr_d  = (seed_i == '0) ? DEFAULT_SEED : seed_i;
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else begin
         if (handshake) begin
            cnt_d = cnt_q + 16'd1;
         end
         if (advance) begin
            lfsr_d = lfsr_next;
            if (reject) begin
               valid_d = 1'b0;
            end else begin
               rand_d  = cand;
               valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_UNSEEDED;
         lfsr_q  <= '0;
         rand_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         rand_q  <= rand_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rand_valid_o = valid_q;
   assign rand_o       = rand_q;
   assign seeded_o     = (state_q == ST_RUN);
   assign gen_cnt_o    = cnt_q;

endmodule : prng_stream

// File: tb/tb_prng_stream.sv
// ---------------------------------------------------------------------------
// tb_prng_stream
//   Bench for prng_stream. Instance A uses the default parameters, instance B
//   uses OUT_WIDTH=4 for the nonzero-mode run. A cycle-level reference model
//   of the generator rules runs alongside both instances.
// ---------------------------------------------------------------------------
module tb_prng_stream;

   logic clk = 1'b0;
   logic rst;

   logic       a_sv, a_rdy, a_vld, a_seeded;
   logic [7:0] a_seed, a_rand;
   logic [1:0] a_mode;
   logic [15:0] a_cnt;

   logic       b_sv, b_rdy, b_vld, b_seeded;
   logic [7:0] b_seed;
   logic [3:0] b_rand;
   logic [1:0] b_mode;
   logic [15:0] b_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state, index 0 = A, 1 = B
   int m_lfsr[2], m_rand[2], m_cnt[2];
   bit m_valid[2], m_seeded[2];

   typedef struct {
      logic [7:0] seed;
      logic [1:0] mode;
      logic [7:0] exp[5];
   } vec_t;

   vec_t vecs[4];

   always #5 clk = ~clk;

   prng_stream dut_a (
      .clk_i(clk), .rst_i(rst), .seed_valid_i(a_sv), .seed_i(a_seed),
      .mode_i(a_mode), .rand_ready_i(a_rdy), .rand_valid_o(a_vld),
      .rand_o(a_rand), .seeded_o(a_seeded), .gen_cnt_o(a_cnt)
   );

   prng_stream #(.WIDTH(8), .OUT_WIDTH(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .seed_valid_i(b_sv), .seed_i(b_seed),
      .mode_i(b_mode), .rand_ready_i(b_rdy), .rand_valid_o(b_vld),
      .rand_o(b_rand), .seeded_o(b_seeded), .gen_cnt_o(b_cnt)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One Galois step written as plain arithmetic on an integer
   function automatic int gstep(int s);
      if (s % 2 == 1) return (s / 2) ^ 'hB8;
      return s / 2;
   endfunction

   task automatic mzero(int i);
      m_lfsr[i] = 0; m_rand[i] = 0; m_cnt[i] = 0;
      m_valid[i] = 0; m_seeded[i] = 0;
   endtask

   task automatic upd(int i, bit sv, int sd, int md, bit rdy, int ow);
      int nxt, cand;
      if (!rst) begin
         mzero(i);
         return;
      end
      if (sv) begin
         m_lfsr[i]   = (sd == 0) ? 1 : sd;
         m_valid[i]  = 0;
         m_seeded[i] = 1;
      end else if (m_seeded[i] && (!m_valid[i] || rdy)) begin
         if (m_valid[i]) m_cnt[i] = (m_cnt[i] + 1) % 65536;
         nxt = gstep(m_lfsr[i]);
         m_lfsr[i] = nxt;
         cand = (md == 1) ? nxt % 4 : nxt % (1 << ow);
         if (md == 2 && cand == 0) begin
            m_valid[i] = 0;
         end else begin
            m_rand[i]  = cand;
            m_valid[i] = 1;
         end
      end
   endtask

   task automatic cmp_all();
      chk("a_valid",  32'(a_vld),    32'(m_valid[0]));
      chk("a_rand",   32'(a_rand),   32'(m_rand[0]));
      chk("a_cnt",    32'(a_cnt),    32'(m_cnt[0]));
      chk("a_seeded", 32'(a_seeded), 32'(m_seeded[0]));
      chk("b_valid",  32'(b_vld),    32'(m_valid[1]));
      chk("b_rand",   32'(b_rand),   32'(m_rand[1]));
      chk("b_cnt",    32'(b_cnt),    32'(m_cnt[1]));
      chk("b_seeded", 32'(b_seeded), 32'(m_seeded[1]));
   endtask

   task automatic step();
      @(posedge clk);
      upd(0, a_sv, int'(a_seed), int'(a_mode), a_rdy, 8);
      upd(1, b_sv, int'(b_seed), int'(b_mode), b_rdy, 4);
      #1;
      cmp_all();
   endtask

   initial begin
      logic [7:0] words[256];
      bit         seen[256];
      int         dups, zeros, acc, cyc;
      logic [15:0] c0;

      vecs[0] = '{seed: 8'h01, mode: 2'd0, exp: '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3}};
      vecs[1] = '{seed: 8'h01, mode: 2'd1, exp: '{8'h00, 8'h00, 8'h02, 8'h03, 8'h03}};
      vecs[2] = '{seed: 8'h00, mode: 2'd0, exp: '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3}};
      vecs[3] = '{seed: 8'h00, mode: 2'd3, exp: '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3}};

      a_sv = 0; a_seed = 0; a_mode = 0; a_rdy = 0;
      b_sv = 0; b_seed = 0; b_mode = 0; b_rdy = 0;
      rst = 1'b0;
      mzero(0); mzero(1);
      #1;
      cmp_all();
      step(); step();
      rst = 1'b1;
      step(); step();

      // ---------------- table-driven known sequences
      for (int v = 0; v < 4; v++) begin
         a_sv = 1; a_seed = vecs[v].seed; a_mode = vecs[v].mode; a_rdy = 1;
         step();
         a_sv = 0;
         chk("vec_seed_novalid", 32'(a_vld), 32'd0);
         for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("vec%0d_valid%0d", v, k), 32'(a_vld), 32'd1);
            chk($sformatf("vec%0d_word%0d", v, k), 32'(a_rand), 32'(vecs[v].exp[k]));
         end
      end

      // ---------------- full period from a zero seed
      a_sv = 1; a_seed = 8'h00; a_mode = 0; a_rdy = 1;
      step();
      a_sv = 0;
      for (int k = 0; k < 256; k++) begin
         step();
         words[k] = a_rand;
      end
      dups = 0; zeros = 0;
      for (int k = 0; k < 256; k++) seen[k] = 0;
      for (int k = 0; k < 255; k++) begin
         if (seen[words[k]]) dups++;
         seen[words[k]] = 1;
         if (words[k] == 8'h00) zeros++;
      end
      chk("period_repeats", 32'(dups), 32'd0);
      chk("period_zero_state", 32'(zeros), 32'd0);
      chk("period_wrap_word", 32'(words[255]), 32'hB8);

      // ---------------- backpressure hold
      a_sv = 1; a_seed = 8'h01; a_mode = 0; a_rdy = 1;
      step();
      a_sv = 0;
      step();
      chk("hold_first", 32'(a_rand), 32'hB8);
      c0 = a_cnt;
      a_rdy = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_word", 32'(a_rand), 32'hB8);
         chk("hold_valid", 32'(a_vld), 32'd1);
         chk("hold_cnt", 32'(a_cnt), 32'(c0));
      end
      a_mode = 1;   // must not touch the held word
      step();
      chk("hold_mode_change", 32'(a_rand), 32'hB8);
      a_mode = 0; a_rdy = 1;
      step();
      chk("release_word", 32'(a_rand), 32'h5C);
      chk("release_cnt", 32'(a_cnt), 32'(c0 + 16'd1));

      // ---------------- seed during a held word
      a_rdy = 0;
      step();
      a_sv = 1; a_seed = 8'h17;
      step();
      a_sv = 0;
      chk("reseed_drop_valid", 32'(a_vld), 32'd0);
      chk("reseed_cnt", 32'(a_cnt), 32'(c0 + 16'd1));
      a_rdy = 1;
      step();
      chk("reseed_first", 32'(a_rand), 32'hB3);
      chk("reseed_first_valid", 32'(a_vld), 32'd1);

      // ---------------- randomized traffic on A
      for (int k = 0; k < 1500; k++) begin
         a_rdy  = ($urandom_range(0, 3) != 0);
         a_mode = 2'($urandom_range(0, 3));
         a_sv   = ($urandom_range(0, 49) == 0);
         a_seed = 8'($urandom_range(0, 255));
         step();
      end
      a_sv = 0;

      // ---------------- OUT_WIDTH=4, nonzero mode, 1000 words
      b_sv = 1; b_seed = 8'h5A; b_mode = 2; b_rdy = 1;
      step();
      b_sv = 0;
      acc = 0; zeros = 0; cyc = 0;
      while (acc < 1000 && cyc < 3000) begin
         step();
         cyc++;
         if (b_vld) begin
            acc++;
            if (b_rand == 4'h0) zeros++;
         end
      end
      chk("nz_words_done", 32'(acc), 32'd1000);
      chk("nz_zero_words", 32'(zeros), 32'd0);

      // ---------------- asynchronous reset mid-stream
      a_sv = 1; a_seed = 8'h33; a_rdy = 1;
      step();
      a_sv = 0;
      step(); step();
      #3;
      rst = 1'b0;
      mzero(0); mzero(1);
      #1;
      cmp_all();
      chk("rst_async_valid", 32'(a_vld), 32'd0);
      step(); step();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("post_rst_idle", 32'(a_vld), 32'd0);
      end
      a_sv = 1; a_seed = 8'h01; a_mode = 0;
      step();
      a_sv = 0;
      chk("post_rst_seed_wait", 32'(a_vld), 32'd0);
      step();
      chk("post_rst_first", 32'(a_rand), 32'hB8);
      chk("post_rst_seeded", 32'(a_seeded), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_prng_stream

// File: doc/prng_stream.md
PRNG_STREAM -- requirements
Module: prng_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning LFSR state width (legal 4..32).
REQ-002 SHALL have parameter OUT_WIDTH, default 8, meaning output word width (legal 2..WIDTH).
REQ-003 SHALL have parameter TAPS, default 8'hB8, meaning Galois feedback mask (x^8+x^6+x^5+x^4+1).
REQ-004 SHALL have parameter DEFAULT_SEED, default 1, meaning substitute for an all-zero seed.
REQ-005 SHALL have port clk_i  in  1  clock; rst_i is asynchronous, active-low reset; clock clk_i.
REQ-006 SHALL have port rst_i  in  1  asynchronous active-low reset.
REQ-007 SHALL have port seed_valid_i  in  1  load seed_i this cycle.
REQ-008 SHALL have port seed_i  in  WIDTH  seed value.
REQ-009 SHALL have port mode_i  in  2  0: full OUT_WIDTH range; 1: 0..3; 2: 1..2^OUT_WIDTH-1; 3: reserved, acts as 0.
REQ-010 SHALL have port rand_ready_i  in  1  consumer accepts rand_o.
REQ-011 SHALL have port rand_valid_o  out  1  rand_o holds a valid number.
REQ-012 SHALL have port rand_o  out  OUT_WIDTH  random number.
REQ-013 SHALL have port seeded_o  out  1  a seed has been loaded since reset.
REQ-014 SHALL have port gen_cnt_o  out  16  count of accepted handshakes, wraps at 16'hFFFF->0.

Function
REQ-015 SHALL keep two states: UNSEEDED (no generation, rand_valid_o=0) and RUN.
REQ-016 SHALL leave UNSEEDED only on seed_valid_i=1; once seeded, it SHALL never return to UNSEEDED except through reset.
REQ-017 SHALL load lfsr_q <= (seed_i==0 ? DEFAULT_SEED : seed_i), clear rand_valid_o, and set seeded_o on seed_valid_i=1, from any state.
REQ-018 SHALL give seed load priority over the handshake; a pending unaccepted word is discarded and not counted.
REQ-019 SHALL define one Galois step as: next = lfsr_q>>1, XORed with TAPS when lfsr_q[0]=1.
REQ-020 SHALL, in RUN without seed load and with (rand_valid_o==0 or rand_ready_i==1), advance lfsr_q to next and derive the candidate from next[OUT_WIDTH-1:0].
REQ-021 SHALL form the candidate as follows: mode 0/3 is next[OUT_WIDTH-1:0]; mode 1 is zero-extended next[1:0]; mode 2 is next[OUT_WIDTH-1:0] with 0 rejected.
REQ-022 SHALL, on a rejected candidate, set rand_valid_o <= 0 and advance again next cycle; otherwise register rand_o <= candidate and rand_valid_o <= 1.
REQ-023 SHALL hold lfsr_q, rand_o and rand_valid_o stable while rand_valid_o=1 and rand_ready_i=0.
REQ-024 SHALL apply a mode_i change only to the next generated word and never alter a held word.
REQ-025 SHALL give a latency of seed_valid_i at cycle N to first rand_valid_o=1 at N+2; with rand_ready_i held at 1, one word per cycle.
REQ-026 SHALL increment gen_cnt_o on each cycle with rand_valid_o & rand_ready_i.
REQ-027 SHALL, with the default parameters and a nonzero seed, have a sequence period of 255 that never reaches state 0.

Reset
REQ-028 SHALL, on rst_i=0, asynchronously clear lfsr_q, rand_o, rand_valid_o, seeded_o and gen_cnt_o to 0 and enter UNSEEDED.
REQ-029 SHALL, on reset mid-stream, drop any held word, and SHALL produce no output after release until a new seed is loaded.

Structure
REQ-030 SHALL place mode encodings, DEFAULT_TAPS_8 (8'hB8) and the state enum in package prng_pkg.
REQ-031 SHALL implement the single-step next-state in sub-module lfsr_galois_step (combinational, parameterised on WIDTH and TAPS).

Verification
REQ-032 SHALL cover: seed 8'h01, mode 0, ready=1 -> rand_o B8,5C,2E,17,B3 on consecutive cycles starting 2 cycles after the seed.
REQ-033 SHALL cover: seed 8'h01, mode 1 -> rand_o 0,0,2,3,3.
REQ-034 SHALL cover: seed 8'h00 -> sequence identical to seed 8'h01; 255 words run with no repeat before index 255, then B8 again.
REQ-035 SHALL cover: ready low 3 cycles after the first word -> rand_o held at B8 with valid=1 and gen_cnt_o unchanged; on release, 5C follows.
REQ-036 SHALL cover: WIDTH=8, OUT_WIDTH=4, mode 2, 1000 words -> no zero output and valid gaps only on rejected candidates.
REQ-037 SHALL cover: rst_i pulsed mid-stream -> all outputs 0 immediately; no valid until the next seed; seed during a held word -> word dropped, new sequence begins 2 cycles later.
